bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
//
// PURPOSE
// - Shares the single external pipelined Wishbone master port between the two
//   internal masters: instruction fetch (S1) and loadstore (S2).
// - Sits between the fetch/loadstore bus ports and the core's top-level wb_* port.
// - Grants the bus for a whole cycle (cyc high) and routes ack/data back only to the owner.
// - Tracks outstanding requests so ownership never changes while acks are still in flight.
//
// PARAMETERS
// - MAX_OUTSTANDING  4  max accepted-but-unacked strobes per grant (>=1); sets counter width
// - STARVE_LIMIT     8  S1 wait cycles before forced S1 grant (used only with BUS_ARB_ANTISTARVE_EN)
//
// PORTS
// - clk_i                  in   1   clock
// - rst_i                  in   1   synchronous reset, active-high
// - s1_wb_adr_i/dat_i      in   32  fetch address / write data
// - s1_wb_sel_i            in   4   fetch byte select
// - s1_wb_we_i/stb_i/cyc_i in   1   fetch we / strobe / cycle
// - s1_wb_dat_o            out  32  fetch read data
// - s1_wb_ack_o/stall_o    out  1   fetch ack / stall
// - s2_wb_*                        same set as s1_wb_*, loadstore side
// - m_wb_adr_o/dat_o       out  32  external address / write data
// - m_wb_sel_o             out  4   external byte select
// - m_wb_we_o/stb_o/cyc_o  out  1   external we / strobe / cycle
// - m_wb_dat_i             in   32  external read data
// - m_wb_ack_i/stall_i     in   1   external ack / stall
// - grant_o                out  2   current owner: 00 none, 01 S1, 10 S2
//
// BEHAVIOUR
// - Reset: state IDLE, grant_o=00, outstanding=0, starve counter=0.
// - Reset outputs: all m_wb_* outputs 0; s*_ack_o=0, s*_stall_o=1, s*_dat_o=0.
// - States: IDLE, OWN_S1, OWN_S2; grant is registered.
// - Request seen at edge N: owner is valid from cycle N+1; no combinational path cyc->grant.
// - IDLE: if s2_cyc_i -> OWN_S2; else if s1_cyc_i -> OWN_S1; else stay. S2 wins ties.
// - While OWN_x:
//   - m_wb_{adr,dat,sel,we,stb,cyc}_o = sx_*_i.
//   - sx_stall_o = m_wb_stall_i | (outstanding==MAX_OUTSTANDING).
//   - sx_ack_o = m_wb_ack_i; sx_dat_o = m_wb_dat_i.
// - At outstanding==MAX_OUTSTANDING: m_wb_stb_o forced 0 until an ack decrements the count.
// - Non-owner: stall_o=1, ack_o=0, dat_o=0; its stb is never forwarded.
// - outstanding: +1 on (m_wb_stb_o & !m_wb_stall_i); -1 on m_wb_ack_i.
//   - Accept and ack in the same cycle: count unchanged.
//   - Ack with outstanding==0: ignored, count stays 0.
// - Release: owner cyc_i low AND outstanding==0 at edge N.
//   - Re-arbitrate in that same edge using the IDLE rules; the releasing master is not
//     requesting. The new owner drives from N+1, so there are no dead cycles.
// - Owner cyc_i low with outstanding>0: keep ownership until all acks return.
//   - Acks are still routed to that master; m_wb_cyc_o stays 1 until outstanding==0.
// - Reset mid-cycle: at the next edge, state IDLE and count 0; late external acks are dropped.
//
// CONFIGURATION
// - BUS_ARB_ANTISTARVE_EN defined:
//   - starve counter +1 each cycle s1_cyc_i=1 while S1 is not the owner;
//     cleared when S1 is granted.
//   - At STARVE_LIMIT, the next arbitration grants S1 even if S2 requests.
//     The counter saturates at STARVE_LIMIT.
// - BUS_ARB_ANTISTARVE_EN undefined: strict S2 priority; no starve counter is synthesised.
//
// TESTING
// - Reset then idle -> grant_o=00, m_wb_cyc_o=0, s1/s2 stall_o=1 for 10 cycles.
// - s1_cyc=stb=1 adr=0x100 at cycle 0 -> grant_o=01 and m_wb_adr_o=0x100 at cycle 1;
//   ack+dat 0xDEADBEEF -> s1_dat_o=0xDEADBEEF, s2_ack_o=0.
// - s1 and s2 cyc rise together -> S2 owns first; S2 drops cyc after its ack ->
//   grant_o=01 on the next cycle.
// - S2 issues 5 back-to-back stb, stall_i=0, no acks -> 4 accepted, s2_stall_o=1 on the 5th;
//   one ack -> 5th accepted the next cycle.
// - S2 drops cyc with 2 outstanding -> grant_o stays 10 until both acks arrive,
//   then S1 is granted.
// - ANTISTARVE_EN, S2 requests continuously, S1 waits -> S1 is granted after the
//   8 wait cycles, at the first S2 release.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master pipelined Wishbone arbiter: fetch (S1) and loadstore (S2) share one external port.
// Optional S1 anti-starvation is built when BUS_ARB_ANTISTARVE_EN is defined.
module bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s1_wb_adr_i,
  input  logic [31:0] s1_wb_dat_i,
  input  logic [3:0]  s1_wb_sel_i,
  input  logic        s1_wb_we_i,
  input  logic        s1_wb_stb_i,
  input  logic        s1_wb_cyc_i,
  output logic [31:0] s1_wb_dat_o,
  output logic        s1_wb_ack_o,
  output logic        s1_wb_stall_o,
  input  logic [31:0] s2_wb_adr_i,
  input  logic [31:0] s2_wb_dat_i,
  input  logic [3:0]  s2_wb_sel_i,
  input  logic        s2_wb_we_i,
  input  logic        s2_wb_stb_i,
  input  logic        s2_wb_cyc_i,
  output logic [31:0] s2_wb_dat_o,
  output logic        s2_wb_ack_o,
  output logic        s2_wb_stall_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_cyc_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_stall_i,
  output logic [1:0]  grant_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING == 0 || STARVE_LIMIT == 0) begin : g_param_check
    $error("bus_arbiter: MAX_OUTSTANDING and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_S1 = 2'b01,
    OWN_S2 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             full;
  logic             accept;
  logic             own_cyc;
  logic             force_s1;

  assign full    = (outst_q == CNT_MAX);
  assign grant_o = 2'(state_q);

`ifdef BUS_ARB_ANTISTARVE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;

  // Counts S1 wait cycles, saturating; cleared on the edge S1 is granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (state_d == OWN_S1) begin
      starve_q <= '0;
    end else if (s1_wb_cyc_i && (state_q != OWN_S1) && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + STARVE_W'(1);
    end
  end

  assign force_s1 = (starve_q == STARVE_MAX);
`else
  assign force_s1 = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
    end
  end

  // Owner routing, outstanding tracking and arbitration.
  always_comb begin
    m_wb_adr_o    = '0;
    m_wb_dat_o    = '0;
    m_wb_sel_o    = '0;
    m_wb_we_o     = 1'b0;
    m_wb_stb_o    = 1'b0;
    m_wb_cyc_o    = 1'b0;
    s1_wb_dat_o   = '0;
    s1_wb_ack_o   = 1'b0;
    s1_wb_stall_o = 1'b1;
    s2_wb_dat_o   = '0;
    s2_wb_ack_o   = 1'b0;
    s2_wb_stall_o = 1'b1;
    own_cyc       = 1'b0;
    state_d       = state_q;
    outst_d       = outst_q;

    case (state_q)
      OWN_S1: begin
        m_wb_adr_o    = s1_wb_adr_i;
        m_wb_dat_o    = s1_wb_dat_i;
        m_wb_sel_o    = s1_wb_sel_i;
        m_wb_we_o     = s1_wb_we_i;
        m_wb_stb_o    = s1_wb_stb_i & ~full;
        m_wb_cyc_o    = s1_wb_cyc_i | (outst_q != '0);
        s1_wb_stall_o = m_wb_stall_i | full;
        s1_wb_ack_o   = m_wb_ack_i;
        s1_wb_dat_o   = m_wb_dat_i;
        own_cyc       = s1_wb_cyc_i;
      end
      OWN_S2: begin
        m_wb_adr_o    = s2_wb_adr_i;
        m_wb_dat_o    = s2_wb_dat_i;
        m_wb_sel_o    = s2_wb_sel_i;
        m_wb_we_o     = s2_wb_we_i;
        m_wb_stb_o    = s2_wb_stb_i & ~full;
        m_wb_cyc_o    = s2_wb_cyc_i | (outst_q != '0);
        s2_wb_stall_o = m_wb_stall_i | full;
        s2_wb_ack_o   = m_wb_ack_i;
        s2_wb_dat_o   = m_wb_dat_i;
        own_cyc       = s2_wb_cyc_i;
      end
      default: ;
    endcase

    accept = m_wb_stb_o & ~m_wb_stall_i;

    // A simultaneous accept and ack cancel; stray acks at zero are dropped.
    if (accept && !m_wb_ack_i) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!accept && m_wb_ack_i && (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end

    // Release and re-grant on the same edge so there is no dead cycle.
    if ((state_q == IDLE) || (!own_cyc && (outst_q == '0))) begin
      if (force_s1 && s1_wb_cyc_i) begin
        state_d = OWN_S1;
      end else if (s2_wb_cyc_i) begin
        state_d = OWN_S2;
      end else if (s1_wb_cyc_i) begin
        state_d = OWN_S1;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int MAX_OUT = 4;
  localparam int STARVE  = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] s1_wb_adr_i, s1_wb_dat_i, s2_wb_adr_i, s2_wb_dat_i;
  logic [3:0]  s1_wb_sel_i, s2_wb_sel_i;
  logic        s1_wb_we_i, s1_wb_stb_i, s1_wb_cyc_i;
  logic        s2_wb_we_i, s2_wb_stb_i, s2_wb_cyc_i;
  logic [31:0] s1_wb_dat_o, s2_wb_dat_o;
  logic        s1_wb_ack_o, s1_wb_stall_o, s2_wb_ack_o, s2_wb_stall_o;
  logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_stb_o, m_wb_cyc_o, m_wb_ack_i, m_wb_stall_i;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: owner 0 none / 1 S1 / 2 S2, pending acks, S1 wait count.
  int md_owner, md_pend, md_starve;

  bus_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s1_wb_adr_i(s1_wb_adr_i), .s1_wb_dat_i(s1_wb_dat_i), .s1_wb_sel_i(s1_wb_sel_i),
    .s1_wb_we_i(s1_wb_we_i), .s1_wb_stb_i(s1_wb_stb_i), .s1_wb_cyc_i(s1_wb_cyc_i),
    .s1_wb_dat_o(s1_wb_dat_o), .s1_wb_ack_o(s1_wb_ack_o), .s1_wb_stall_o(s1_wb_stall_o),
    .s2_wb_adr_i(s2_wb_adr_i), .s2_wb_dat_i(s2_wb_dat_i), .s2_wb_sel_i(s2_wb_sel_i),
    .s2_wb_we_i(s2_wb_we_i), .s2_wb_stb_i(s2_wb_stb_i), .s2_wb_cyc_i(s2_wb_cyc_i),
    .s2_wb_dat_o(s2_wb_dat_o), .s2_wb_ack_o(s2_wb_ack_o), .s2_wb_stall_o(s2_wb_stall_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cyc_o(m_wb_cyc_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .m_wb_stall_i(m_wb_stall_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    s1_wb_adr_i = '0; s1_wb_dat_i = '0; s1_wb_sel_i = '0;
    s1_wb_we_i = 1'b0; s1_wb_stb_i = 1'b0; s1_wb_cyc_i = 1'b0;
    s2_wb_adr_i = '0; s2_wb_dat_i = '0; s2_wb_sel_i = '0;
    s2_wb_we_i = 1'b0; s2_wb_stb_i = 1'b0; s2_wb_cyc_i = 1'b0;
    m_wb_dat_i = '0; m_wb_ack_i = 1'b0; m_wb_stall_i = 1'b0;
  endtask

  // Advance one clock; returns just after the falling edge where inputs are driven.
  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      #1;
      total++;
      if ({grant_o, m_wb_cyc_o, s1_wb_stall_o, s2_wb_stall_o} !== 5'b00011) begin
        bad++;
        $display("FAIL reset_idle got=%b exp=%b", {grant_o, m_wb_cyc_o, s1_wb_stall_o, s2_wb_stall_o}, 5'b00011);
      end
      total++;
      if ({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o, s1_wb_ack_o, s2_wb_ack_o,
           s1_wb_dat_o, s2_wb_dat_o} !== '0) begin
        bad++;
        $display("FAIL reset_outputs got adr=%h stb=%b s1dat=%h s2dat=%h exp all zero",
                 m_wb_adr_o, m_wb_stb_o, s1_wb_dat_o, s2_wb_dat_o);
      end
    end
  endtask

  task automatic test_single_read();
    clear_inputs();
    s1_wb_cyc_i = 1'b1; s1_wb_stb_i = 1'b1; s1_wb_adr_i = 32'h100;
    #1;
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL single_no_comb_grant got=%b exp=00", grant_o); end
    cycle();
    #1;
    total++;
    if ({grant_o, m_wb_adr_o, m_wb_stb_o, m_wb_cyc_o} !== {2'b01, 32'h100, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_grant got grant=%b adr=%h stb=%b cyc=%b exp grant=01 adr=00000100 stb=1 cyc=1",
               grant_o, m_wb_adr_o, m_wb_stb_o, m_wb_cyc_o);
    end
    cycle();
    s1_wb_stb_i = 1'b0; m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hDEADBEEF;
    #1;
    total++;
    if ({s1_wb_ack_o, s1_wb_dat_o, s2_wb_ack_o, s2_wb_dat_o} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL single_ack got s1ack=%b s1dat=%h s2ack=%b s2dat=%h exp 1 deadbeef 0 0",
               s1_wb_ack_o, s1_wb_dat_o, s2_wb_ack_o, s2_wb_dat_o);
    end
    cycle();
    m_wb_ack_i = 1'b0; s1_wb_cyc_i = 1'b0;
    cycle();
    #1;
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL single_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_tie();
    clear_inputs();
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1; s2_wb_adr_i = 32'h300;
    cycle();
    #1;
    total++;
    if ({grant_o, s1_wb_stall_o, m_wb_adr_o} !== {2'b10, 1'b1, 32'h300}) begin
      bad++;
      $display("FAIL tie_s2_first got grant=%b s1stall=%b adr=%h exp 10 1 00000300", grant_o, s1_wb_stall_o, m_wb_adr_o);
    end
    cycle();
    s2_wb_stb_i = 1'b0; m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hCAFE0001;
    #1;
    total++;
    if ({s2_wb_ack_o, s2_wb_dat_o, s1_wb_ack_o, s1_wb_dat_o} !== {1'b1, 32'hCAFE0001, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL tie_ack_route got s2ack=%b s2dat=%h s1ack=%b s1dat=%h", s2_wb_ack_o, s2_wb_dat_o, s1_wb_ack_o, s1_wb_dat_o);
    end
    cycle();
    m_wb_ack_i = 1'b0; s2_wb_cyc_i = 1'b0;
    cycle();
    #1;
    total++;
    if (grant_o !== 2'b01) begin bad++; $display("FAIL tie_handover got=%b exp=01", grant_o); end
    s1_wb_cyc_i = 1'b0;
    cycle();
  endtask

  task automatic test_outstanding();
    clear_inputs();
    s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1; s2_wb_adr_i = 32'h200;
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({s2_wb_stall_o, m_wb_stb_o} !== 2'b01) begin
        bad++;
        $display("FAIL outst_accept_%0d got stall,stb=%b exp=01", k, {s2_wb_stall_o, m_wb_stb_o});
      end
      cycle();
    end
    #1;
    total++;
    if ({s2_wb_stall_o, m_wb_stb_o, m_wb_cyc_o} !== 3'b101) begin
      bad++;
      $display("FAIL outst_full got stall,stb,cyc=%b exp=101", {s2_wb_stall_o, m_wb_stb_o, m_wb_cyc_o});
    end
    m_wb_ack_i = 1'b1;
    #1;
    total++;
    if ({s2_wb_stall_o, s2_wb_ack_o} !== 2'b11) begin
      bad++;
      $display("FAIL outst_full_ack got stall,ack=%b exp=11", {s2_wb_stall_o, s2_wb_ack_o});
    end
    cycle();
    m_wb_ack_i = 1'b0;
    #1;
    total++;
    if ({s2_wb_stall_o, m_wb_stb_o} !== 2'b01) begin
      bad++;
      $display("FAIL outst_fifth got stall,stb=%b exp=01", {s2_wb_stall_o, m_wb_stb_o});
    end
    cycle();
    #1;
    total++;
    if (s2_wb_stall_o !== 1'b1) begin bad++; $display("FAIL outst_refull got=%b exp=1", s2_wb_stall_o); end
    s2_wb_stb_i = 1'b0; m_wb_ack_i = 1'b1;
    repeat (4) cycle();
    m_wb_ack_i = 1'b0; s2_wb_cyc_i = 1'b0;
    cycle();
    #1;
    total++;
    if (grant_o !== 2'b00) begin bad++; $display("FAIL outst_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_drain();
    clear_inputs();
    s2_wb_cyc_i = 1'b1; s2_wb_stb_i = 1'b1;
    cycle();
    cycle();
    cycle();
    s2_wb_stb_i = 1'b0; s2_wb_cyc_i = 1'b0; s1_wb_cyc_i = 1'b1;
    #1;
    total++;
    if ({grant_o, m_wb_cyc_o} !== 3'b101) begin
      bad++;
      $display("FAIL drain_hold got grant,cyc=%b exp=101", {grant_o, m_wb_cyc_o});
    end
    cycle();
    m_wb_ack_i = 1'b1; m_wb_dat_i = 32'h12345678;
    #1;
    total++;
    if ({grant_o, s2_wb_ack_o, s2_wb_dat_o, s1_wb_ack_o} !== {2'b10, 1'b1, 32'h12345678, 1'b0}) begin
      bad++;
      $display("FAIL drain_ack1 got grant=%b s2ack=%b s2dat=%h s1ack=%b", grant_o, s2_wb_ack_o, s2_wb_dat_o, s1_wb_ack_o);
    end
    cycle();
    #1;
    total++;
    if ({grant_o, s2_wb_ack_o} !== 3'b101) begin
      bad++;
      $display("FAIL drain_ack2 got grant,ack=%b exp=101", {grant_o, s2_wb_ack_o});
    end
    cycle();
    m_wb_ack_i = 1'b0;
    #1;
    total++;
    if ({grant_o, m_wb_cyc_o} !== 3'b100) begin
      bad++;
      $display("FAIL drain_empty got grant,cyc=%b exp=100", {grant_o, m_wb_cyc_o});
    end
    cycle();
    #1;
    total++;
    if (grant_o !== 2'b01) begin bad++; $display("FAIL drain_regrant got=%b exp=01", grant_o); end
    s1_wb_cyc_i = 1'b0;
    cycle();
  endtask

  task automatic test_starve();
`ifdef BUS_ARB_ANTISTARVE_EN
    logic [1:0] exp_grant = 2'b01;
`else
    logic [1:0] exp_grant = 2'b10;
`endif
    clear_inputs();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1;
    repeat (11) cycle();
    #1;
    total++;
    if (grant_o !== 2'b10) begin bad++; $display("FAIL starve_s2_holds got=%b exp=10", grant_o); end
    s1_wb_cyc_i = 1'b0; s2_wb_cyc_i = 1'b0;
    cycle();
    s1_wb_cyc_i = 1'b1; s2_wb_cyc_i = 1'b1;
    cycle();
    #1;
    total++;
    if (grant_o !== exp_grant) begin bad++; $display("FAIL starve_regrant got=%b exp=%b", grant_o, exp_grant); end
    clear_inputs();
    cycle();
  endtask

  function automatic int model_pick();
`ifdef BUS_ARB_ANTISTARVE_EN
    if (md_starve >= STARVE && s1_wb_cyc_i) return 1;
`endif
    if (s2_wb_cyc_i) return 2;
    if (s1_wb_cyc_i) return 1;
    return 0;
  endfunction

  task automatic test_random();
    logic [31:0] e_adr, e_dat, e_s1dat, e_s2dat;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc, e_s1ack, e_s2ack, e_s1st, e_s2st, own_cyc;
    int          nxt;
    bit          full;
    clear_inputs();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    md_owner = 0; md_pend = 0; md_starve = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) s1_wb_cyc_i = ~s1_wb_cyc_i;
      if ($urandom_range(0, 7) == 0) s2_wb_cyc_i = ~s2_wb_cyc_i;
      s1_wb_stb_i = 1'($urandom_range(0, 1));
      s2_wb_stb_i = 1'($urandom_range(0, 1));
      s1_wb_we_i = 1'($urandom_range(0, 1));
      s2_wb_we_i = 1'($urandom_range(0, 1));
      s1_wb_adr_i = $urandom(); s1_wb_dat_i = $urandom(); s1_wb_sel_i = 4'($urandom());
      s2_wb_adr_i = $urandom(); s2_wb_dat_i = $urandom(); s2_wb_sel_i = 4'($urandom());
      m_wb_dat_i = $urandom();
      m_wb_ack_i = ($urandom_range(0, 2) == 0);
      m_wb_stall_i = ($urandom_range(0, 3) == 0);
      rst_i = ($urandom_range(0, 299) == 0);
      #1;
      full = (md_pend == MAX_OUT);
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
      e_s1dat = '0; e_s2dat = '0; e_s1ack = 1'b0; e_s2ack = 1'b0; e_s1st = 1'b1; e_s2st = 1'b1;
      own_cyc = 1'b0;
      if (md_owner == 1) begin
        e_adr = s1_wb_adr_i; e_dat = s1_wb_dat_i; e_sel = s1_wb_sel_i; e_we = s1_wb_we_i;
        e_stb = s1_wb_stb_i && !full; e_cyc = s1_wb_cyc_i || (md_pend > 0);
        e_s1st = m_wb_stall_i || full; e_s1ack = m_wb_ack_i; e_s1dat = m_wb_dat_i;
        own_cyc = s1_wb_cyc_i;
      end else if (md_owner == 2) begin
        e_adr = s2_wb_adr_i; e_dat = s2_wb_dat_i; e_sel = s2_wb_sel_i; e_we = s2_wb_we_i;
        e_stb = s2_wb_stb_i && !full; e_cyc = s2_wb_cyc_i || (md_pend > 0);
        e_s2st = m_wb_stall_i || full; e_s2ack = m_wb_ack_i; e_s2dat = m_wb_dat_i;
        own_cyc = s2_wb_cyc_i;
      end
      total++;
      if (grant_o !== 2'(md_owner)) begin
        bad++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant_o, 2'(md_owner));
      end
      total++;
      if ({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o, m_wb_cyc_o} !==
          {e_adr, e_dat, e_sel, e_we, e_stb, e_cyc}) begin
        bad++;
        $display("FAIL rand_master c=%0d got adr=%h dat=%h sel=%h we,stb,cyc=%b exp adr=%h dat=%h sel=%h we,stb,cyc=%b",
                 c, m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, {m_wb_we_o, m_wb_stb_o, m_wb_cyc_o},
                 e_adr, e_dat, e_sel, {e_we, e_stb, e_cyc});
      end
      total++;
      if ({s1_wb_ack_o, s1_wb_stall_o, s1_wb_dat_o} !== {e_s1ack, e_s1st, e_s1dat}) begin
        bad++;
        $display("FAIL rand_s1 c=%0d got ack,stall=%b dat=%h exp ack,stall=%b dat=%h",
                 c, {s1_wb_ack_o, s1_wb_stall_o}, s1_wb_dat_o, {e_s1ack, e_s1st}, e_s1dat);
      end
      total++;
      if ({s2_wb_ack_o, s2_wb_stall_o, s2_wb_dat_o} !== {e_s2ack, e_s2st, e_s2dat}) begin
        bad++;
        $display("FAIL rand_s2 c=%0d got ack,stall=%b dat=%h exp ack,stall=%b dat=%h",
                 c, {s2_wb_ack_o, s2_wb_stall_o}, s2_wb_dat_o, {e_s2ack, e_s2st}, e_s2dat);
      end
      // Advance the model to what should hold after this edge.
      if (rst_i) begin
        md_owner = 0; md_pend = 0; md_starve = 0;
      end else begin
        nxt = md_owner;
        if (md_owner == 0 || (!own_cyc && md_pend == 0)) nxt = model_pick();
        if (e_stb && !m_wb_stall_i && !m_wb_ack_i) md_pend++;
        else if (!(e_stb && !m_wb_stall_i) && m_wb_ack_i && md_pend > 0) md_pend--;
        if (nxt == 1) md_starve = 0;
        else if (s1_wb_cyc_i && md_owner != 1 && md_starve < STARVE) md_starve++;
        md_owner = nxt;
      end
      cycle();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    @(negedge clk_i);
    test_reset();
    test_single_read();
    test_tie();
    test_outstanding();
    test_drain();
    test_starve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
